// File: rtl/matmul_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : matmul_job_arbiter
// Description : Round-robin arbiter that shares one 3x3 8-bit matrix-multiply
//               datapath between NREQ requesters. It registers the winner's
//               A/B operands into the multiplier and captures a guaranteed-fresh
//               C result. It returns the result, tagged with the requester id,
//               on a valid/ready response channel. A watchdog returns an error
//               response when the multiplier stalls.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               req_valid/req_ready - per-requester handshake (ready one-hot)
//               req_a/req_b         - per-requester operands, 72 bits per slot
//               rsp_valid/rsp_ready - response handshake
//               rsp_id/rsp_c/rsp_err- response owner, result, timeout flag
//               mm_a/mm_b           - registered operands to the multiplier
//               mm_c/mm_done        - multiplier result and done flag
//               busy                - high whenever a job is in progress
//               job_count           - completed responses, wraps at 16 bits
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_job_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*72-1:0] req_a,
    input  logic [NREQ*72-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [71:0]        rsp_c,
    output logic               rsp_err,
    output logic [71:0]        mm_a,
    output logic [71:0]        mm_b,
    input  logic [71:0]        mm_c,
    input  logic               mm_done,
    output logic               busy,
    output logic [15:0]        job_count
);

    localparam int         c_TOW     = $clog2(TIMEOUT + 1);
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [IDW-1:0]   r_rr;
    logic [71:0]      r_mm_a;
    logic [71:0]      r_mm_b;
    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [71:0]      r_rsp_c;
    logic             r_rsp_err;
    logic [15:0]      r_job_count;
    logic             r_done_seen;
    logic [c_TOW-1:0] r_to_cnt;

    logic             w_found;
    logic [IDW-1:0]   w_win;
    logic [71:0]      w_win_a;
    logic [71:0]      w_win_b;
    logic             w_capture;
    logic             w_timeout;

    // First pass finds the lowest requester overall (the wrap-around
    // candidate); the second pass overrides it with the lowest requester at
    // or above the pointer, giving "first at or after rr, with wrap".
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_found = 1'b1;
                w_win   = IDW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i >= int'(r_rr))) begin
                w_win = IDW'(i);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        w_win_a   = '0;
        w_win_b   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IDW'(i)) begin
                req_ready[i] = (r_state == c_ST_IDLE) && w_found;
                w_win_a      = req_a[72*i +: 72];
                w_win_b      = req_b[72*i +: 72];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state. The first mm_done sample after an accept may still reflect
    // the previous operands, so only the second one is trusted. A capture
    // takes precedence over a timeout that lands on the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (mm_done && r_done_seen) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_ST_RESP;
                end else if (r_to_cnt == c_TOW'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr        <= '0;
            r_mm_a      <= '0;
            r_mm_b      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_c     <= '0;
            r_rsp_err   <= 1'b0;
            r_job_count <= '0;
            r_done_seen <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_found) begin
                        r_mm_a      <= w_win_a;
                        r_mm_b      <= w_win_b;
                        r_rsp_id    <= w_win;
                        r_rr        <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
                        r_done_seen <= 1'b0;
                        r_to_cnt    <= '0;
                    end
                end
                c_ST_WAIT: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    if (mm_done) begin
                        r_done_seen <= 1'b1;
                    end
                    if (w_capture) begin
                        r_rsp_c     <= mm_c;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                    end else if (w_timeout) begin
                        r_rsp_c     <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                    end
                end
                c_ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_job_count <= r_job_count + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mm_a      = r_mm_a;
    assign mm_b      = r_mm_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_c     = r_rsp_c;
    assign rsp_err   = r_rsp_err;
    assign job_count = r_job_count;
    assign busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
